// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with flush bubble, halt and saturating counters
module pc_sequencer #(
  parameter int              PC_W       = 13,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter logic [3:0]      OP_BEQ     = 4'hC,
  parameter logic [3:0]      OP_BGT     = 4'hD,
  parameter logic [3:0]      OP_HALT    = 4'hF,
  parameter int              CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic [3:0]       OP,
  input  logic             jump_en,
  input  logic             BEQ,
  input  logic             BGT,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  PC,
  output logic             instr_valid,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [7:0]       taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FLUSH  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [CNT_W-1:0] cycle_nxt;
  logic [7:0]       taken_nxt;

  logic             is_halt;
  logic             taken;
  logic [CNT_W-1:0] cycle_inc;
  logic [7:0]       taken_inc;

  // Decode halt/branch conditions and saturating increments from current-cycle inputs
  always_comb begin
    is_halt   = (OP == OP_HALT);
    taken     = jump_en | ((OP == OP_BEQ) & BEQ) | ((OP == OP_BGT) & BGT);
    cycle_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_ONE;
    taken_inc = (&taken_cnt) ? taken_cnt : taken_cnt + 8'd1;
  end

  // Register state, PC and counters; reset returns everything to the idle start point
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      PC        <= START_ADDR;
      cycle_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      state     <= state_nxt;
      PC        <= pc_nxt;
      cycle_cnt <= cycle_nxt;
      taken_cnt <= taken_nxt;
    end
  end

  // Next-state, next-PC, counter updates and decode-stage qualifiers
  always_comb begin
    state_nxt   = state;
    pc_nxt      = PC;
    cycle_nxt   = cycle_cnt;
    taken_nxt   = taken_cnt;
    instr_valid = 1'b0;
    done        = 1'b0;

    case (state)
      S_IDLE: begin
        // Stall has no effect here; Start alone launches execution
        pc_nxt = START_ADDR;
        if (Start) begin
          state_nxt = S_RUN;
          cycle_nxt = '0;
          taken_nxt = '0;
        end
      end

      S_RUN: begin
        if (!Stall) begin
          instr_valid = 1'b1;
          cycle_nxt   = cycle_inc;
          // Halt outranks any branch request on the same instruction
          if (is_halt) begin
            state_nxt = S_HALTED;
          end else if (taken) begin
            pc_nxt    = Target;
            state_nxt = S_FLUSH;
            taken_nxt = taken_inc;
          end else begin
            pc_nxt = PC + PC_ONE;
          end
        end
      end

      S_FLUSH: begin
        // PC sits on the target for one unstalled cycle so the ROM output catches up
        if (!Stall) begin
          cycle_nxt = cycle_inc;
          state_nxt = S_RUN;
        end
      end

      S_HALTED: begin
        done = 1'b1;
        if (Start) begin
          state_nxt = S_RUN;
          pc_nxt    = START_ADDR;
          cycle_nxt = '0;
          taken_nxt = '0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        pc_nxt    = START_ADDR;
      end
    endcase
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-flow controller for the processor datapath. It owns the 13-bit program counter and sequences fetch through four states: start, normal increment, taken jump/branch with a one-cycle flush bubble, and halt. It consumes the `jump_en` output of the control decoder plus the ALU `BEQ`/`BGT` flags. It drives the instruction ROM address and a valid qualifier to the decode stage.

Parameters:
PC_W, 13, program counter width
START_ADDR, 0, PC loaded on start
OP_BEQ, 4'hC, opcode of branch-if-equal
OP_BGT, 4'hD, opcode of branch-if-greater
OP_HALT, 4'hF, opcode of halt
CNT_W, 16, cycle counter width

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  one-cycle pulse; begins execution from IDLE or HALTED
Stall  input  1  freezes PC, state and counters for the cycle
OP  input  4  opcode of the instruction currently at PC
jump_en  input  1  unconditional-jump request from control decoder
BEQ  input  1  ALU equal flag
BGT  input  1  ALU greater-than flag
Target  input  PC_W  branch/jump destination (from target LUT)
PC  output  PC_W  instruction ROM address
instr_valid  output  1  OP at PC is to be executed this cycle
done  output  1  program halted
cycle_cnt  output  CNT_W  cycles spent in RUN+FLUSH, saturating
taken_cnt  output  8  taken jumps/branches, saturating

Behaviour:
- Reset is asynchronous and active-high; one clock, CLK. Reset at any time, including mid-run or mid-flush, forces all of the following immediately:
  - state=IDLE, PC=START_ADDR
  - instr_valid=0, done=0
  - cycle_cnt=0, taken_cnt=0
- All other updates occur on the rising CLK edge.
- States: IDLE, RUN, FLUSH, HALTED. instr_valid=1 only in RUN with Stall=0. done=1 only in HALTED.
- IDLE: PC=START_ADDR. When Start=1, go to RUN next cycle; counters are cleared.
- RUN, Stall=0, conditions evaluated in priority order:
  1. OP==OP_HALT: go to HALTED, PC holds.
  2. taken = jump_en | (OP==OP_BEQ & BEQ) | (OP==OP_BGT & BGT). If taken: PC<=Target, state<=FLUSH, taken_cnt+=1.
  3. Otherwise PC<=PC+1, modulo 2^PC_W (so 13'h1FFF wraps to 0).
- FLUSH: exactly one non-stalled cycle. instr_valid=0, PC holds Target so the synchronous ROM read settles. Next state is RUN. Branch/jump/halt inputs are ignored.
- Stall=1 in RUN or FLUSH: PC, state and both counters hold; instr_valid=0. Stall has priority over halt and branch. A FLUSH interrupted by Stall resumes and still lasts one non-stalled cycle.
- cycle_cnt increments on every non-stalled cycle in RUN or FLUSH and saturates at 2^CNT_W-1. taken_cnt saturates at 8'hFF. Both hold in HALTED.
- HALTED: PC, counters and done hold. Start=1 moves to RUN next cycle with:
  - PC=START_ADDR
  - done=0
  - counters cleared
- Start is ignored in RUN and FLUSH. Stall is ignored in IDLE and HALTED.
- Branch uses flags of the current cycle; no flag latching is performed in this block.

Test Plan:
- Reset asserted mid-RUN at PC=0x012 asynchronously -> PC=0, state IDLE, instr_valid=0, done=0 before the next CLK edge. Start pulse -> PC increments 0,1,2,3 on successive edges with instr_valid=1.
- PC=5, OP=kjmp, jump_en=1, Target=0x040 -> next PC=0x040 with instr_valid=0 for one cycle, then PC=0x041. taken_cnt=1.
- OP=OP_BEQ with BEQ=0 -> PC+1. OP=OP_BEQ with BEQ=1, Target=0x100 -> PC=0x100. OP=OP_BGT, BGT=1, Target=0x002 -> PC=0x002. taken_cnt=2.
- Stall=1 for 3 cycles during RUN and again during FLUSH -> PC, cycle_cnt and taken_cnt frozen. FLUSH still yields exactly one bubble after Stall drops.
- PC=0x1FFF, no branch -> PC wraps to 0x0000. OP=OP_HALT together with jump_en=1 -> HALTED, done=1, PC unchanged, taken_cnt unchanged. Start -> RUN at PC=0 with counters cleared.
- Run 70000 cycles without halt -> cycle_cnt saturates at 0xFFFF. 300 taken jumps -> taken_cnt saturates at 0xFF.
